// File: rtl/ippro_stream_pkg.sv
// rtl/ippro_stream_pkg.sv - shared constants and state encoding for IPPro stream blocks
package ippro_stream_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  // core enable-to-valid latency (1) plus the registered core enable (1)
  localparam int DEFAULT_SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } stream_state_t;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/put_skid_fifo.sv
// rtl/put_skid_fifo.sv - small register FIFO with push/pop/count/head for core skid absorption
module put_skid_fifo
  import ippro_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_SKID_DEPTH,
  localparam int CW        = count_width(DEPTH),
  localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] head,
  output logic [CW-1:0]         count,
  output logic                  full
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic                  do_push;
  logic                  do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  // a pop in the same cycle frees the slot, so a push into a full FIFO is still accepted
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/put_module.sv
// rtl/put_module.sv - writes IPPro core results into the output FIFO with skid absorption and core stall
module put_module
  import ippro_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int SKID_DEPTH = DEFAULT_SKID_DEPTH
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ENABLE,
  input  logic                  CORE_VALID,
  input  logic [DATA_WIDTH-1:0] CORE_DATA,
  input  logic                  FULL,
  output logic                  ENABLE_CORE,
  output logic                  FIFO_WRITE_EN,
  output logic [DATA_WIDTH-1:0] FIFO_DATA,
  output logic [1:0]            SKID_COUNT,
  output logic                  OVERFLOW
);

  localparam int CW = count_width(SKID_DEPTH);

  stream_state_t         state;
  stream_state_t         state_next;
  logic [CW-1:0]         skid_count;
  logic [DATA_WIDTH-1:0] skid_head;
  logic                  skid_full;
  logic                  skid_empty;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic                  next_empty;
  logic                  full_q;
  logic                  overflow_q;

  assign skid_empty    = (skid_count == '0);
  assign FIFO_WRITE_EN = !RESET && ENABLE && !FULL && (!skid_empty || CORE_VALID);
  // skid always drains ahead of live core data to keep strict ordering
  assign FIFO_DATA     = skid_empty ? CORE_DATA : skid_head;

  assign pop  = FIFO_WRITE_EN && !skid_empty;
  assign push = CORE_VALID && !(FIFO_WRITE_EN && skid_empty);
  assign drop = push && skid_full && !pop;

  always_comb begin
    next_empty = 1'b0;
    if (skid_empty) begin
      next_empty = !push;
    end else if (skid_count == CW'(1)) begin
      next_empty = pop && !push;
    end
  end

  put_skid_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (SKID_DEPTH)
  ) u_skid (
    .clk      (CLK),
    .reset    (RESET),
    .push     (push),
    .pop      (pop),
    .push_data(CORE_DATA),
    .head     (skid_head),
    .count    (skid_count),
    .full     (skid_full)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (ENABLE) begin
          state_next = next_empty ? STREAM : DRAIN;
        end
      end
      STREAM: begin
        if (!ENABLE) begin
          state_next = IDLE;
        end else if (!next_empty) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!ENABLE) begin
          state_next = IDLE;
        end else if (next_empty) begin
          state_next = STREAM;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      full_q     <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state  <= state_next;
      full_q <= FULL;
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // STREAM is entered exactly when ENABLE was high and the skid ends up empty,
  // so the core enable is that registered state qualified by last cycle's FULL
  assign ENABLE_CORE = (state == STREAM) && !full_q;
  assign SKID_COUNT  = 2'(skid_count);
  assign OVERFLOW    = overflow_q;

endmodule

// File: tb/tb_put_module.sv
// tb/tb_put_module.sv - randomized self-checking bench for put_module against a queue model
module tb_put_module;

  localparam int DW   = 32;
  localparam int SKID = 2;

  logic          CLK;
  logic          RESET;
  logic          ENABLE;
  logic          CORE_VALID;
  logic [DW-1:0] CORE_DATA;
  logic          FULL;
  logic          ENABLE_CORE;
  logic          FIFO_WRITE_EN;
  logic [DW-1:0] FIFO_DATA;
  logic [1:0]    SKID_COUNT;
  logic          OVERFLOW;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] wr_log[$];
  logic [DW-1:0] issued[$];
  logic          m_ec;
  logic          m_ovf;
  logic          ec_prev;

  put_module dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ENABLE       (ENABLE),
    .CORE_VALID   (CORE_VALID),
    .CORE_DATA    (CORE_DATA),
    .FULL         (FULL),
    .ENABLE_CORE  (ENABLE_CORE),
    .FIFO_WRITE_EN(FIFO_WRITE_EN),
    .FIFO_DATA    (FIFO_DATA),
    .SKID_COUNT   (SKID_COUNT),
    .OVERFLOW     (OVERFLOW)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // one clock: drive, check against the model mid-cycle, then advance the model at the edge
  task automatic cycle(input logic rst, input logic en, input logic fl,
                       input logic v, input logic [DW-1:0] d);
    logic          exp_we;
    logic [DW-1:0] exp_data;
    int            sz0;
    RESET      = rst;
    ENABLE     = en;
    FULL       = fl;
    CORE_VALID = v;
    CORE_DATA  = d;
    #1;
    exp_we   = !rst && en && !fl && (mq.size() > 0 || v);
    exp_data = (mq.size() > 0) ? mq[0] : d;
    check_val("write_en", 32'(FIFO_WRITE_EN), 32'(exp_we));
    if (exp_we) check_val("fifo_data", FIFO_DATA, exp_data);
    check_val("skid_count", 32'(SKID_COUNT), 32'(mq.size()));
    check_val("enable_core", 32'(ENABLE_CORE), 32'(m_ec));
    check_val("overflow", 32'(OVERFLOW), 32'(m_ovf));
    if (FIFO_WRITE_EN === 1'b1) wr_log.push_back(FIFO_DATA);
    ec_prev = ENABLE_CORE;
    @(posedge CLK);
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_ec  = 1'b0;
    end else begin
      sz0 = mq.size();
      if (exp_we && sz0 > 0) void'(mq.pop_front());
      if (v && !(exp_we && sz0 == 0)) begin
        if (mq.size() < SKID) mq.push_back(d);
        else m_ovf = 1'b1;
      end
      m_ec = en && !fl && (mq.size() == 0);
    end
    @(negedge CLK);
  endtask

  initial begin
    logic [DW-1:0] nxt;
    int            full_cnt;
    logic          v;
    logic          fl;
    logic          en;
    logic          rst;

    RESET = 1'b1; ENABLE = 1'b0; CORE_VALID = 1'b0; CORE_DATA = '0; FULL = 1'b0;
    m_ec = 1'b0; m_ovf = 1'b0; ec_prev = 1'b0;
    @(posedge CLK);
    @(negedge CLK);

    // reset held with enable and valid asserted
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, $urandom());

    // straight pass-through of 1..8
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    wr_log.delete();
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, DW'(i + 1));
    check_val("t2_count", 32'(wr_log.size()), 32'd8);
    for (int i = 0; i < wr_log.size(); i++) check_val("t2_data", wr_log[i], 32'(i + 1));

    // FULL for 4 cycles from the cycle 0x12 arrives
    wr_log.delete();
    nxt = 32'h10;
    full_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      v = ec_prev && (nxt < 32'h20);
      if (v && nxt == 32'h12) full_cnt = 4;
      fl = (full_cnt > 0);
      if (full_cnt > 0) full_cnt--;
      cycle(1'b0, 1'b1, fl, v, v ? nxt : $urandom());
      if (fl && full_cnt == 1) begin
        check_val("t3_skid2", 32'(SKID_COUNT), 32'd2);
        check_val("t3_stall", 32'(ENABLE_CORE), 32'd0);
      end
      if (v) nxt++;
    end
    check_val("t3_count", 32'(wr_log.size()), 32'd16);
    for (int i = 0; i < wr_log.size(); i++) check_val("t3_data", wr_log[i], 32'h10 + 32'(i));
    check_val("t3_ovf", 32'(OVERFLOW), 32'd0);

    // misbehaving core: three valids into a full FIFO
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'hA0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'hA1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'hA2);
    check_val("t4_skid", 32'(SKID_COUNT), 32'd2);
    check_val("t4_ovf", 32'(OVERFLOW), 32'd1);
    wr_log.delete();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check_val("t4_count", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      check_val("t4_first", wr_log[0], 32'hA0);
      check_val("t4_second", wr_log[1], 32'hA1);
    end
    check_val("t4_ovf_sticky", 32'(OVERFLOW), 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
    check_val("t4_ovf_clr", 32'(OVERFLOW), 32'd0);

    // enable dropped with one entry retained
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h55);
    wr_log.delete();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check_val("t5_nowrite", 32'(wr_log.size()), 32'd0);
    check_val("t5_skid", 32'(SKID_COUNT), 32'd1);
    check_val("t5_ec", 32'(ENABLE_CORE), 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check_val("t5_count", 32'(wr_log.size()), 32'd1);
    if (wr_log.size() > 0) check_val("t5_data", wr_log[0], 32'h55);
    check_val("t5_ec_back", 32'(ENABLE_CORE), 32'd1);

    // reset pulse with a full skid
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h66);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h67);
    check_val("t6_skid2", 32'(SKID_COUNT), 32'd2);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
    check_val("t6_skid0", 32'(SKID_COUNT), 32'd0);
    check_val("t6_ec", 32'(ENABLE_CORE), 32'd0);
    wr_log.delete();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check_val("t6_nowrite", 32'(wr_log.size()), 32'd0);

    // random well-behaved core; FULL toggles every cycle at first
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    wr_log.delete();
    issued.delete();
    nxt = 32'h1000;
    for (int c = 0; c < 1500; c++) begin
      en = ($urandom_range(0, 9) != 0);
      fl = (c < 100) ? c[0] : ($urandom_range(0, 2) == 0);
      v  = ec_prev && ($urandom_range(0, 3) != 0);
      cycle(1'b0, en, fl, v, v ? nxt : $urandom());
      if (v) begin
        issued.push_back(nxt);
        nxt++;
      end
    end
    for (int c = 0; c < 10; c++) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check_val("rand_count", 32'(wr_log.size()), 32'(issued.size()));
    for (int i = 0; i < wr_log.size() && i < issued.size(); i++)
      check_val("rand_order", wr_log[i], issued[i]);
    check_val("rand_ovf", 32'(OVERFLOW), 32'd0);

    // random misbehaving core with occasional resets
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      en  = ($urandom_range(0, 5) != 0);
      fl  = ($urandom_range(0, 1) == 0);
      v   = ($urandom_range(0, 1) == 0);
      cycle(rst, en, fl, v, $urandom());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
